vluint7_enc: RTL and testbench

VLUINT7_ENC -- requirements
Module: vluint7_enc

---
 rtl/vluint7_pkg.sv | 22 ++
 rtl/vluint7_zigzag.sv | 15 +
 rtl/vluint7_enc.sv | 98 +++++++++
 tb/tb_vluint7_enc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vluint7_pkg.sv
// Shared types and constants for the vluint7 encoder.
// Optional build macro: VLUINT7_ZIGZAG_EN (signed zigzag input mapping).
package vluint7_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int WORD_WIDTH     = 32;
  localparam int MEM_DATA_WIDTH = 8;

  localparam int VLU_GROUP_BITS = 7;
  localparam int VLU_CONT_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int vlu_max_bytes(input int ww);
    return (ww + VLU_GROUP_BITS - 1) / VLU_GROUP_BITS;
  endfunction

endpackage

// File: rtl/vluint7_zigzag.sv
// Zigzag map: small-magnitude signed values become small unsigned values.
// Only instantiated when VLUINT7_ZIGZAG_EN is defined.
module vluint7_zigzag #(
  parameter int WW = 32
) (
  input  logic [WW-1:0] value,
  output logic [WW-1:0] zz
);

  logic signed [WW-1:0] sv;

  assign sv = $signed(value);
  assign zz = (value << 1) ^ WW'(sv >>> (WW - 1));

endmodule

// File: rtl/vluint7_enc.sv
// LEB128-style 7-bit group encoder writing one byte per granted cycle.
// Optional build macro: VLUINT7_ZIGZAG_EN (signed zigzag input mapping).
module vluint7_enc
  import vluint7_pkg::*;
#(
  parameter int AW = MEM_ADDR_WIDTH,
  parameter int WW = WORD_WIDTH,
  parameter int DW = MEM_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          beg,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] value,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_gnt,
  output logic [AW-1:0] addr_out,
  output logic [3:0]    len,
  output logic          done
);

  state_t state, state_nx;

  logic [WW-1:0] enc_val;
  logic [WW-1:0] rem;
  logic [AW-1:0] cur_addr;
  logic [3:0]    cnt;
  logic          more;

`ifdef VLUINT7_ZIGZAG_EN
  vluint7_zigzag #(.WW(WW)) u_zigzag (
    .value (value),
    .zz    (enc_val)
  );
`else
  assign enc_val = value;
`endif

  assign more = |(rem >> VLU_GROUP_BITS);

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (beg) state_nx = EMIT;
      end
      EMIT: begin
        mem_we   = 1'b1;
        mem_addr = cur_addr;
        mem_wdata[VLU_GROUP_BITS-1:0] =
          rem[VLU_GROUP_BITS-1:0];
        mem_wdata[VLU_CONT_BIT] = more;
        if (mem_gnt && !more) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      cur_addr <= '0;
      cnt      <= '0;
      addr_out <= '0;
      len      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && beg) begin
        rem      <= enc_val;
        cur_addr <= addr;
        cnt      <= '0;
      end else if (state == EMIT && mem_gnt) begin
        rem      <= rem >> VLU_GROUP_BITS;
        cur_addr <= cur_addr + AW'(1);
        cnt      <= cnt + 4'd1;
        // results latch on the last grant so they are valid during DONE
        if (!more) begin
          addr_out <= cur_addr + AW'(1);
          len      <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vluint7_enc.sv
// Directed bench for vluint7_enc (default AW=16, WW=32).
// Define VLUINT7_ZIGZAG_EN to run the zigzag vectors instead.
module tb_vluint7_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        beg;
  logic [15:0] addr;
  logic [31:0] value;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_gnt;
  logic [15:0] addr_out;
  logic [3:0]  len;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cap_b [8];
  logic [15:0] cap_a [8];
  int          cap_n;
  int          cap_dc;
  int          cap_hold;

  vluint7_enc dut (
    .clk       (clk),
    .reset     (reset),
    .beg       (beg),
    .addr      (addr),
    .value     (value),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_gnt   (mem_gnt),
    .addr_out  (addr_out),
    .len       (len),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one encode and records writes; cycle 1 = first EMIT cycle.
  // First `stall` cycles hold mem_gnt low; cap_hold counts stall
  // cycles whose bus shows the expected first byte.
  task automatic run_enc(input logic [31:0] v, input logic [15:0] a,
                         input int stall, input logic [7:0] b0);
    value = v;
    addr  = a;
    beg   = 1'b1;
    tick();
    beg      = 1'b0;
    cap_n    = 0;
    cap_dc   = -1;
    cap_hold = 0;
    for (int c = 1; c <= 24 && cap_dc < 0; c++) begin
      mem_gnt = (c <= stall) ? 1'b0 : 1'b1;
      #0;
      if (c <= stall && mem_we && mem_addr == a && mem_wdata == b0)
        cap_hold++;
      if (mem_we && mem_gnt && cap_n < 8) begin
        cap_b[cap_n] = mem_wdata;
        cap_a[cap_n] = mem_addr;
        cap_n++;
      end
      if (done) cap_dc = c;
      tick();
    end
    mem_gnt = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, mem_we, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000", {busy, mem_we, done});
    end
    checks++;
    if ({mem_addr, mem_wdata, addr_out, len} !== 44'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {mem_addr, mem_wdata, addr_out, len});
    end
    reset = 1'b1;
    tick();
  endtask

`ifndef VLUINT7_ZIGZAG_EN
  task automatic test_zero;
    run_enc(32'd0, 16'h0010, 0, 8'h00);
    checks++;
    if (cap_n !== 1 || cap_b[0] !== 8'h00 || cap_a[0] !== 16'h0010) begin
      errors++;
      $display("FAIL zero_write got n=%0d %h@%h want 1 00@0010",
               cap_n, cap_b[0], cap_a[0]);
    end
    checks++;
    if (cap_dc !== 2) begin
      errors++;
      $display("FAIL zero_done_cycle got %0d want 2", cap_dc);
    end
    checks++;
    if (addr_out !== 16'h0011 || len !== 4'd1) begin
      errors++;
      $display("FAIL zero_result got %h/%0d want 0011/1", addr_out, len);
    end
  endtask

  task automatic test_300;
    run_enc(32'd300, 16'h0020, 0, 8'hAC);
    checks++;
    if (cap_n !== 2 || cap_b[0] !== 8'hAC || cap_a[0] !== 16'h0020 ||
        cap_b[1] !== 8'h02 || cap_a[1] !== 16'h0021) begin
      errors++;
      $display("FAIL v300_bytes got n=%0d %h@%h %h@%h want AC@0020 02@0021",
               cap_n, cap_b[0], cap_a[0], cap_b[1], cap_a[1]);
    end
    checks++;
    if (addr_out !== 16'h0022 || len !== 4'd2 || cap_dc !== 3) begin
      errors++;
      $display("FAIL v300_result got %h/%0d dc=%0d want 0022/2 dc=3",
               addr_out, len, cap_dc);
    end
  endtask

  task automatic test_max;
    logic [39:0] got;
    run_enc(32'hFFFF_FFFF, 16'h0100, 0, 8'hFF);
    got = {cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4]};
    checks++;
    if (cap_n !== 5 || got !== 40'hFF_FF_FF_FF_0F) begin
      errors++;
      $display("FAIL max_bytes got n=%0d %h want 5 FFFFFFFF0F", cap_n, got);
    end
    checks++;
    if (len !== 4'd5 || cap_dc !== 6 || addr_out !== 16'h0105) begin
      errors++;
      $display("FAIL max_result got %0d dc=%0d %h want 5 dc=6 0105",
               len, cap_dc, addr_out);
    end
  endtask

  task automatic test_stall;
    run_enc(32'd300, 16'h0020, 3, 8'hAC);
    checks++;
    if (cap_hold !== 3) begin
      errors++;
      $display("FAIL stall_hold got %0d stable cycles want 3", cap_hold);
    end
    checks++;
    if (cap_dc !== 6 || cap_n !== 2 || cap_b[1] !== 8'h02) begin
      errors++;
      $display("FAIL stall_done got dc=%0d n=%0d b1=%h want dc=6 n=2 02",
               cap_dc, cap_n, cap_b[1]);
    end
  endtask

  task automatic test_wrap;
    run_enc(32'd300, 16'hFFFF, 0, 8'hAC);
    checks++;
    if (cap_a[0] !== 16'hFFFF || cap_a[1] !== 16'h0000 ||
        addr_out !== 16'h0001) begin
      errors++;
      $display("FAIL wrap got %h %h out=%h want FFFF 0000 0001",
               cap_a[0], cap_a[1], addr_out);
    end
  endtask

  task automatic test_ignore_beg;
    int extra;
    value   = 32'd300;
    addr    = 16'h0030;
    mem_gnt = 1'b1;
    beg     = 1'b1;
    tick();
    beg = 1'b0;
    tick();
    beg   = 1'b1;
    value = 32'd5;
    tick();
    beg   = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_we || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_beg got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    value   = 32'hFFFF_FFFF;
    addr    = 16'h0040;
    mem_gnt = 1'b1;
    beg     = 1'b1;
    tick();
    beg = 1'b0;
    tick();
    checks++;
    if (!(mem_we && mem_addr == 16'h0041)) begin
      errors++;
      $display("FAIL mid_byte2 got we=%b %h want 1 0041", mem_we, mem_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, mem_we, done} !== 3'b000 ||
        {mem_addr, mem_wdata, addr_out, len} !== 44'd0) begin
      errors++;
      $display("FAIL mid_reset got %b %h want 000 0",
               {busy, mem_we, done},
               {mem_addr, mem_wdata, addr_out, len});
    end
    reset = 1'b1;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d pulses want 0", seen);
    end
    run_enc(32'd1, 16'h0050, 0, 8'h01);
    checks++;
    if (cap_n !== 1 || cap_b[0] !== 8'h01 || cap_a[0] !== 16'h0050) begin
      errors++;
      $display("FAIL mid_after got n=%0d %h@%h want 1 01@0050",
               cap_n, cap_b[0], cap_a[0]);
    end
  endtask
`else
  task automatic test_zigzag;
    logic [31:0] vin [3];
    logic [7:0]  exp [3];
    vin = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFC0};
    exp = '{8'h01, 8'h02, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      run_enc(vin[i], 16'h0200, 0, exp[i]);
      checks++;
      if (cap_n !== 1 || cap_b[0] !== exp[i] || len !== 4'd1) begin
        errors++;
        $display("FAIL zigzag_%0d got n=%0d %h len=%0d want 1 %h len=1",
                 i, cap_n, cap_b[0], len, exp[i]);
      end
    end
    run_enc(32'd300, 16'h0300, 0, 8'hD8);
    checks++;
    if (cap_n !== 2 || cap_b[0] !== 8'hD8 || cap_b[1] !== 8'h04) begin
      errors++;
      $display("FAIL zigzag_300 got n=%0d %h %h want 2 D8 04",
               cap_n, cap_b[0], cap_b[1]);
    end
  endtask
`endif

  initial begin
    beg     = 1'b0;
    addr    = '0;
    value   = '0;
    mem_gnt = 1'b1;
    reset   = 1'b0;
    #2;
    test_reset();
`ifndef VLUINT7_ZIGZAG_EN
    test_zero();
    test_300();
    test_max();
    test_stall();
    test_wrap();
    test_ignore_beg();
    test_reset_mid();
`else
    test_zigzag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
